// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: write port, start/status and skewed lane outputs of the skew feeder.
interface systolic_skew_feeder_if #(
    parameter int BITS = 8,
    parameter int DIM  = 8
);
    logic                   wr_en;
    logic [$clog2(DIM)-1:0] wr_addr;
    logic signed [BITS-1:0] wr_data [DIM-1:0];
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   out_valid;
    logic signed [BITS-1:0] dout [DIM-1:0];
    modport master (output wr_en, wr_addr, wr_data, start, input busy, done, out_valid, dout);
    modport slave  (input wr_en, wr_addr, wr_data, start, output busy, done, out_valid, dout);
endinterface

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: stores a DIM x DIM operand tile and streams it diagonally skewed
// into a systolic array, lane i delayed by i cycles, with array enable and done pulse.
module systolic_skew_feeder #(
    parameter int BITS = 8,
    parameter int DIM  = 8
) (
    input logic clk,
    input logic rst,
    systolic_skew_feeder_if.slave bus
);
    localparam int AW = $clog2(DIM);
    localparam int TW = $clog2(2 * DIM);
    localparam logic [TW-1:0] T_LAST = TW'(2 * DIM - 2);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          t_q, t_d;
    logic                   done_q, done_d;
    logic signed [BITS-1:0] mem_q [DIM][DIM];
    logic signed [BITS-1:0] mem_d [DIM][DIM];
    logic signed [BITS-1:0] dout_q [DIM-1:0];
    logic signed [BITS-1:0] dout_d [DIM-1:0];

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        mem_d   = mem_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (bus.wr_en)
                for (int i = 0; i < DIM; i++) mem_d[i][bus.wr_addr] = bus.wr_data[i];
            if (bus.start) begin
                state_d = STREAM;
                t_d     = '0;
            end
        end else if (t_q == T_LAST) begin
            state_d = IDLE;
            t_d     = '0;
            done_d  = 1'b1;
        end else begin
            t_d = t_q + 1'b1;
        end
        // Output registers look ahead to the next state so dout lines up with busy/out_valid.
        for (int i = 0; i < DIM; i++)
            dout_d[i] = (state_d == STREAM && t_d >= TW'(i) && t_d <= TW'(i + DIM - 1))
                        ? mem_d[i][AW'(t_d - TW'(i))] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                dout_q[i] <= '0;
                for (int k = 0; k < DIM; k++) mem_q[i][k] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            done_q  <= done_d;
            mem_q   <= mem_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.busy      = (state_q == STREAM);
    assign bus.out_valid = (state_q == STREAM);
    assign bus.done      = done_q;
    assign bus.dout      = dout_q;
endmodule
